// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
//
// Sink-side sequencer for the two ping-pong line buffers that feed the
// deinterlacer source. It takes the Avalon-ST field stream, drops control
// packets, and writes each video line into buffer 0 or buffer 1 in turn.
// It raises full0/full1 to the source, frees a buffer when the source has read
// a whole line with empty_enable set, and raises ready_to_continue after each
// completed line until the source sends aver_sent.
//
// Optional feature macro: LBC_PKT_ERR_EN
//   When defined, the ports o_pkt_err (sticky) and o_err_cnt (8-bit, saturating)
//   are added. They flag video packets that end early and surplus beats after a
//   full field.
//
// Ports
//   i_clk                          system clock, rising edge
//   i_rst_n                        asynchronous reset, active low
//   i_din_data/valid/sop/eop       Avalon-ST sink
//   o_din_ready                    sink backpressure (combinational)
//   o_wr_req0/1, o_wr_data         write strobes and shared write data
//   i_rd_req0/1                    read strobes from the source
//   i_empty_enable0/1              release a buffer at the end of its read-out
//   o_full0/1                      buffer holds a complete line
//   o_ready_to_continue            a new line is buffered
//   i_aver_sent                    acknowledge of ready_to_continue
//   o_pkt_err, o_err_cnt           (LBC_PKT_ERR_EN only) malformed packet flags
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int WIDTH       = 640,
  parameter int HALF_HEIGHT = 240
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_din_data,
  input  logic                  i_din_valid,
  input  logic                  i_din_startofpacket,
  input  logic                  i_din_endofpacket,
  output logic                  o_din_ready,
  output logic                  o_wr_req0,
  output logic                  o_wr_req1,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_rd_req0,
  input  logic                  i_rd_req1,
  input  logic                  i_empty_enable0,
  input  logic                  i_empty_enable1,
  output logic                  o_full0,
  output logic                  o_full1,
  output logic                  o_ready_to_continue,
`ifdef LBC_PKT_ERR_EN
  output logic                  o_pkt_err,
  output logic [7:0]            o_err_cnt,
`endif
  input  logic                  i_aver_sent
);

  localparam int PXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LNW = $clog2(HALF_HEIGHT + 1);
  localparam logic [PXW-1:0] PX_LAST = PXW'(WIDTH - 1);
  localparam logic [LNW-1:0] LN_LAST = LNW'(HALF_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CTRL, S_VIDEO, S_DRAIN} pkt_state_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL} buf_state_t;

  pkt_state_t     r_state;
  logic           r_wr_sel;
  logic [PXW-1:0] r_px_cnt;
  logic [LNW-1:0] r_line_cnt;
  logic           r_line_done_d;
  logic           r_rtc;

  logic [1:0]     w_full;
  logic [1:0]     w_wr_req;
  logic [1:0]     w_rd_req;
  logic [1:0]     w_empty_en;
  logic           w_din_ready;
  logic           w_accept;
  logic           w_wr_en;
  logic           w_line_done;

  // Outputs are forced low while reset is held, including the combinational ones.
  assign w_din_ready = i_rst_n & ((r_state != S_VIDEO) | ~w_full[r_wr_sel]);
  assign w_accept    = i_din_valid & w_din_ready;
  assign w_wr_en     = w_accept & (r_state == S_VIDEO);
  assign w_line_done = w_wr_en & (r_px_cnt == PX_LAST);

  assign w_rd_req    = {i_rd_req1, i_rd_req0};
  assign w_empty_en  = {i_empty_enable1, i_empty_enable0};

  assign o_din_ready         = w_din_ready;
  assign o_wr_req0           = w_wr_req[0];
  assign o_wr_req1           = w_wr_req[1];
  assign o_wr_data           = i_rst_n ? i_din_data : '0;
  assign o_full0             = w_full[0];
  assign o_full1             = w_full[1];
  assign o_ready_to_continue = r_rtc;

  // Per-buffer EMPTY -> FILL -> FULL -> EMPTY tracking and read-out counting.
  // Each buffer updates independently, so a write completing on one buffer and
  // a release on the other are both honoured in the same cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      buf_state_t     r_buf_state;
      logic [PXW-1:0] r_rd_cnt;

      assign w_wr_req[gi] = w_wr_en & (r_wr_sel == 1'(gi));
      assign w_full[gi]   = (r_buf_state == B_FULL);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_buf_state <= B_EMPTY;
          r_rd_cnt    <= '0;
        end else begin
          case (r_buf_state)
            B_EMPTY: if (w_wr_req[gi]) r_buf_state <= w_line_done ? B_FULL : B_FILL;
            B_FILL:  if (w_wr_req[gi] && w_line_done) r_buf_state <= B_FULL;
            B_FULL: begin
              if (w_rd_req[gi]) begin
                if (r_rd_cnt == PX_LAST) begin
                  r_rd_cnt <= '0;
                  // Without empty_enable the line is kept for the interpolated line.
                  if (w_empty_en[gi]) r_buf_state <= B_EMPTY;
                end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
                end
              end
            end
            default: r_buf_state <= B_EMPTY;
          endcase
        end
      end
    end
  endgenerate

  // Packet sequencer, pixel/line counters and ready_to_continue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_wr_sel      <= 1'b0;
      r_px_cnt      <= '0;
      r_line_cnt    <= '0;
      r_line_done_d <= 1'b0;
      r_rtc         <= 1'b0;
    end else begin
      r_line_done_d <= w_line_done;

      case (r_state)
        S_IDLE: begin
          // Single-beat packets (SOP with EOP) carry no payload and leave us in IDLE.
          if (w_accept && i_din_startofpacket && !i_din_endofpacket) begin
            if (i_din_data[3:0] == 4'hF) begin
              r_state <= S_CTRL;
            end else if (i_din_data[3:0] == 4'h0) begin
              r_state    <= S_VIDEO;
              r_px_cnt   <= '0;
              r_line_cnt <= '0;
              r_wr_sel   <= 1'b0;
            end
          end
        end
        S_CTRL: if (w_accept && i_din_endofpacket) r_state <= S_IDLE;
        S_VIDEO: begin
          if (w_wr_en) begin
            if (w_line_done) begin
              r_px_cnt   <= '0;
              r_line_cnt <= r_line_cnt + 1'b1;
              r_wr_sel   <= ~r_wr_sel;
            end else begin
              r_px_cnt <= r_px_cnt + 1'b1;
            end
            // An EOP already consumed here means there is nothing left to drain.
            if (i_din_endofpacket)                          r_state <= S_IDLE;
            else if (w_line_done && r_line_cnt == LN_LAST)  r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (w_accept && i_din_endofpacket) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Field completion always coincides with a buffer going FULL, so the
      // delayed line-done pulse covers both set causes. Set beats acknowledge.
      if (r_line_done_d)    r_rtc <= 1'b1;
      else if (i_aver_sent) r_rtc <= 1'b0;
    end
  end

`ifdef LBC_PKT_ERR_EN
  logic r_drain_seen;
  logic w_err_event;

  // Early EOP: the line is not complete, or lines remain in the field.
  // Surplus beats after a full field are counted once per drain.
  assign w_err_event = (w_wr_en && i_din_endofpacket &&
                        (!w_line_done || (r_line_cnt < LN_LAST))) ||
                       (r_state == S_DRAIN && w_accept && !r_drain_seen);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_err    <= 1'b0;
      o_err_cnt    <= '0;
      r_drain_seen <= 1'b0;
    end else begin
      if (r_state != S_DRAIN)                   r_drain_seen <= 1'b0;
      else if (w_accept)                        r_drain_seen <= 1'b1;
      if (w_err_event) begin
        o_pkt_err <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a reduced geometry (8 px x 4 lines).
module tb_line_buffer_ctrl;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int HH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_data;
  logic          din_valid, din_sop, din_eop;
  logic          din_ready, wr_req0, wr_req1;
  logic [DW-1:0] wr_data;
  logic          rd_req0, rd_req1, ee0, ee1;
  logic          full0, full1, rtc, aver_sent;
`ifdef LBC_PKT_ERR_EN
  logic          pkt_err;
  logic [7:0]    err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int wr0_cnt  = 0;
  int wr1_cnt  = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.DATA_WIDTH(DW), .WIDTH(W), .HALF_HEIGHT(HH)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_din_data          (din_data),
    .i_din_valid         (din_valid),
    .i_din_startofpacket (din_sop),
    .i_din_endofpacket   (din_eop),
    .o_din_ready         (din_ready),
    .o_wr_req0           (wr_req0),
    .o_wr_req1           (wr_req1),
    .o_wr_data           (wr_data),
    .i_rd_req0           (rd_req0),
    .i_rd_req1           (rd_req1),
    .i_empty_enable0     (ee0),
    .i_empty_enable1     (ee1),
    .o_full0             (full0),
    .o_full1             (full1),
    .o_ready_to_continue (rtc),
`ifdef LBC_PKT_ERR_EN
    .o_pkt_err           (pkt_err),
    .o_err_cnt           (err_cnt),
`endif
    .i_aver_sent         (aver_sent)
  );

  // Write-strobe monitor: counts pulses seen at each active edge.
  always @(posedge clk) begin
    if (wr_req0) wr0_cnt++;
    if (wr_req1) wr1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    din_valid = v;
    din_data  = d;
    din_sop   = s;
    din_eop   = e;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_req0 = 0; rd_req1 = 0; ee0 = 0; ee1 = 0; aver_sent = 0;
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    $display("reset held: ready=%0b full0=%0b full1=%0b rtc=%0b", din_ready, full0, full1, rtc);
    check("reset_din_ready", 32'(din_ready), 0);
    check("reset_wr_req0",   32'(wr_req0),   0);
    check("reset_full",      32'({full1, full0}), 0);
    check("reset_rtc",       32'(rtc),       0);

    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Control packet: header 0x0F plus 9 beats, none written.
    drive(1'b1, 8'h0F, 1'b1, 1'b0);
    check("idle_ready", 32'(din_ready), 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, i == 8);
      tick();
    end
    $display("ctrl packet done: wr0=%0d wr1=%0d", wr0_cnt, wr1_cnt);
    check("ctrl_no_writes", 32'(wr0_cnt + wr1_cnt), 0);

    // Video packet, line 0 -> buffer 0.
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    for (int p = 0; p < W; p++) begin
      drive(1'b1, 8'(8'h10 + p), 1'b0, 1'b0);
      if (p == 3) begin
        check("line0_wr_data", 32'(wr_data), 32'h13);
        check("line0_wr_req0", 32'({wr_req1, wr_req0}), 32'b01);
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("line0 done: wr0=%0d full0=%0b rtc=%0b", wr0_cnt, full0, rtc);
    check("line0_wr0_count", 32'(wr0_cnt), W);
    check("line0_full0",     32'(full0),   1);
    check("line0_rtc_early", 32'(rtc),     0);
    tick();
    check("line0_rtc_set",   32'(rtc),     1);

    aver_sent = 1'b1; tick(); aver_sent = 1'b0;
    $display("aver_sent pulse: rtc=%0b", rtc);
    check("aver_clears_rtc", 32'(rtc), 0);

    // Read-out without release: buffer 0 stays full.
    rd_req0 = 1'b1; ee0 = 1'b0;
    for (int i = 0; i < W; i++) tick();
    rd_req0 = 1'b0;
    $display("read no release: full0=%0b", full0);
    check("read_keep_full0", 32'(full0), 1);

    // Read-out with release: full drops only after read WIDTH.
    rd_req0 = 1'b1; ee0 = 1'b1;
    for (int i = 0; i < W - 1; i++) tick();
    check("read_w_minus1_full0", 32'(full0), 1);
    tick();
    rd_req0 = 1'b0; ee0 = 1'b0;
    $display("read with release: full0=%0b", full0);
    check("read_release_full0", 32'(full0), 0);

    // Line 1 -> buffer 1, then aver_sent coincident with the new FULL.
    for (int p = 0; p < W; p++) begin
      drive(1'b1, 8'(8'h20 + p), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("line1_wr1_count", 32'(wr1_cnt), W);
    check("line1_full1",     32'(full1),   1);
    aver_sent = 1'b1; tick(); aver_sent = 1'b0;
    $display("line1 done + coincident aver_sent: full1=%0b rtc=%0b", full1, rtc);
    check("set_beats_aver", 32'(rtc), 1);

    // Line 2 -> buffer 0 again.
    for (int p = 0; p < W; p++) begin
      drive(1'b1, 8'(8'h30 + p), 1'b0, 1'b0);
      tick();
    end
    $display("line2 done: wr0=%0d full0=%0b full1=%0b", wr0_cnt, full0, full1);
    check("line2_wr0_count", 32'(wr0_cnt), 2 * W);
    check("both_full",       32'({full1, full0}), 32'b11);

    // Both full with valid data: stalled.
    drive(1'b1, 8'h3F, 1'b0, 1'b0);
    check("stall_ready",  32'(din_ready), 0);
    check("stall_wr_req", 32'({wr_req1, wr_req0}), 0);
    tick(); tick();
    check("stall_wr1_count", 32'(wr1_cnt), W);

    // Release buffer 1 while the stream waits.
    rd_req1 = 1'b1; ee1 = 1'b1;
    for (int i = 0; i < W; i++) tick();
    rd_req1 = 1'b0; ee1 = 1'b0;
    $display("buffer1 released: full1=%0b ready=%0b", full1, din_ready);
    check("release1_full1", 32'(full1),     0);
    check("release1_ready", 32'(din_ready), 1);

    // Line 3 -> buffer 1 while buffer 0 is read out and released in lockstep.
    rd_req0 = 1'b1; ee0 = 1'b1;
    for (int p = 0; p < W; p++) begin
      drive(1'b1, 8'(8'h40 + p), 1'b0, 1'b0);
      tick();
    end
    rd_req0 = 1'b0; ee0 = 1'b0;
    $display("line3 + release0: full0=%0b full1=%0b wr1=%0d", full0, full1, wr1_cnt);
    check("simul_full_bits", 32'({full1, full0}), 32'b10);
    check("line3_wr1_count", 32'(wr1_cnt), 2 * W);

    // Field complete: surplus beats are drained, never written.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    check("drain_ready",  32'(din_ready), 1);
    check("drain_no_wr",  32'({wr_req1, wr_req0}), 0);
    tick();
    drive(1'b1, 8'h56, 1'b0, 1'b1);
    tick();

    // New packet restarts at buffer 0; stop mid-line with reset.
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 8'(8'h60 + p), 1'b0, 1'b0);
      if (p == 0) check("newpkt_wr_sel0", 32'({wr_req1, wr_req0}), 32'b01);
      tick();
    end
    rst_n = 1'b0;
    #1;
    $display("mid-line reset: ready=%0b full0=%0b full1=%0b rtc=%0b", din_ready, full0, full1, rtc);
    check("midreset_ready", 32'(din_ready), 0);
    check("midreset_full",  32'({full1, full0}), 0);
    check("midreset_rtc",   32'(rtc), 0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    for (int p = 0; p < W; p++) begin
      drive(1'b1, 8'(8'h70 + p), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("after reset line: wr0=%0d wr1=%0d full0=%0b full1=%0b", wr0_cnt, wr1_cnt, full0, full1);
    check("restart_wr0_count", 32'(wr0_cnt), 2 * W + 3 + W);
    check("restart_wr1_count", 32'(wr1_cnt), 2 * W);
    check("restart_full",      32'({full1, full0}), 32'b01);

`ifdef LBC_PKT_ERR_EN
    // Early EOP at pixel 5 of line 0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, 8'(8'h80 + p), 1'b0, p == 5);
      tick();
    end
    $display("early eop: pkt_err=%0b err_cnt=%0d", pkt_err, err_cnt);
    check("err_flag",  32'(pkt_err), 1);
    check("err_count", 32'(err_cnt), 1);
    // Back in IDLE: a control packet causes no further error and no writes.
    drive(1'b1, 8'h0F, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h01, 1'b0, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("err_count_hold", 32'(err_cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
